truth_table_sequencer: RTL

- Parametrised, loadable truth-table engine generalising the fixed 4-input/10-output minterm decoder.
- Holds a 2^N_IN x N_OUT function table in flops, written through a simple write port.
- Evaluates the table two ways: registered lookup of a live input vector, or an autonomous sweep of every row with a valid/ready handshake (the hardware equivalent of the bench's truth-table loop).
- Sits between switch/stimulus logic and display/checker logic on the breadboard-style top level.

---
 rtl/truth_table_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: loadable 2^N_IN x N_OUT function table.
// The table is evaluated either by a registered lookup of a live input
// vector (IDLE) or by an autonomous row-by-row sweep with a valid/ready
// handshake (SWEEP), followed by a one-cycle completion pulse (DONE).
module truth_table_sequencer #(
  parameter int N_IN  = 4,   // function inputs, legal range 1..8
  parameter int N_OUT = 10   // function outputs / table row width
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [N_IN-1:0]  wr_addr,
  input  logic [N_OUT-1:0] wr_data,
  input  logic [N_IN-1:0]  in_vec,
  input  logic             start,
  input  logic             out_ready,
  output logic [N_OUT-1:0] f_out,
  output logic [N_IN-1:0]  row_out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int DEPTH = 1 << N_IN;
  // The counter is one bit wider than a row index so the last-row compare
  // stays unambiguous even when DEPTH fills the whole index range.
  localparam logic [N_IN:0]   LAST_ROW = (N_IN + 1)'(DEPTH - 1);
  localparam logic [N_IN-1:0] ROW_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  logic [N_OUT-1:0] tbl_q [DEPTH];
  state_t           state_q;
  logic [N_IN:0]    rowCnt_q;
  logic [N_IN:0]    rowCnt_d;
  logic [N_OUT-1:0] fOut_q;
  logic [N_IN-1:0]  rowOut_q;
  logic             outValid_q;
  logic             busy_q;
  logic             done_q;
  logic             accept;

  // Handshake acceptance and the candidate next row of a sweep.
  always_comb begin
    accept   = outValid_q & out_ready;
    rowCnt_d = rowCnt_q + (N_IN + 1)'(1);
  end

  // Function table storage; writes are honoured in every state and
  // readers in the same cycle still see the old contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= '0;
      end
    end else if (wr_en) begin
      tbl_q[wr_addr] <= wr_data;
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rowCnt_q   <= '0;
      fOut_q     <= '0;
      rowOut_q   <= '0;
      outValid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q     <= 1'b0;
          if (start) begin
            state_q    <= SWEEP;
            rowCnt_q   <= '0;
            fOut_q     <= tbl_q[ROW_ZERO];
            rowOut_q   <= ROW_ZERO;
            outValid_q <= 1'b1;
            busy_q     <= 1'b1;
          end else begin
            fOut_q     <= tbl_q[in_vec];
            rowOut_q   <= in_vec;
            outValid_q <= 1'b0;
            busy_q     <= 1'b0;
          end
        end
        SWEEP: begin
          if (accept) begin
            if (rowCnt_q == LAST_ROW) begin
              state_q    <= DONE;
              outValid_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              rowCnt_q <= rowCnt_d;
              fOut_q   <= tbl_q[rowCnt_d[N_IN-1:0]];
              rowOut_q <= rowCnt_d[N_IN-1:0];
            end
          end else begin
            // Re-read the presented row so a late write reaches the consumer.
            fOut_q <= tbl_q[rowCnt_q[N_IN-1:0]];
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          outValid_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  assign f_out     = fOut_q;
  assign row_out   = rowOut_q;
  assign out_valid = outValid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
